// File: rtl/branch_predictor_unit_if.sv
// Lookup / prediction / resolution bundle between fetch, execute and branch_predictor_unit.
// master = fetch/execute side, slave = predictor.
interface branch_predictor_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int GHR_WIDTH  = 8
);
    logic                  lookupValid;
    logic [ADDR_WIDTH-1:0] lookupPc;
    logic [ADDR_WIDTH-1:0] lookupNpc;
    logic                  lookupIsBranch;

    logic                  predValid;
    logic                  predIsNextPcPredicted;
    logic [ADDR_WIDTH-1:0] predNextPc;
    logic                  predTaken;
    logic [GHR_WIDTH-1:0]  predGhr;

    logic                  updateValid;
    logic [ADDR_WIDTH-1:0] updatePc;
    logic                  updateTaken;
    logic [ADDR_WIDTH-1:0] updateTarget;
    logic [GHR_WIDTH-1:0]  updateGhr;
    logic                  updateMispredict;

    modport master (
        output lookupValid, lookupPc, lookupNpc, lookupIsBranch,
        output updateValid, updatePc, updateTaken, updateTarget, updateGhr, updateMispredict,
        input  predValid, predIsNextPcPredicted, predNextPc, predTaken, predGhr
    );

    modport slave (
        input  lookupValid, lookupPc, lookupNpc, lookupIsBranch,
        input  updateValid, updatePc, updateTaken, updateTarget, updateGhr, updateMispredict,
        output predValid, predIsNextPcPredicted, predNextPc, predTaken, predGhr
    );
endinterface

// File: rtl/branch_predictor_unit.sv
// Branch predictor: 2-bit counter BHT, direct-mapped tagged BTB, speculative GHR with recovery.
// Optional macro BRANCH_PREDICT_GSHARE_EN: BHT index = PC bits XOR GHR (default: bimodal).
module branch_predictor_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BHT_ENTRIES = 256,
    parameter int BTB_ENTRIES = 64,
    parameter int GHR_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    branch_predictor_unit_if.slave bp
);
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = ADDR_WIDTH - BTB_IDX_W - 2;

    logic [1:0]            r_bht     [BHT_ENTRIES];
    logic                  r_btb_vld [BTB_ENTRIES];
    logic [TAG_W-1:0]      r_btb_tag [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] r_btb_tgt [BTB_ENTRIES];
    logic [GHR_WIDTH-1:0]  r_ghr;

    logic                  r_pred_valid;
    logic                  r_pred_npp;
    logic [ADDR_WIDTH-1:0] r_pred_npc;
    logic                  r_pred_taken;
    logic [GHR_WIDTH-1:0]  r_pred_ghr;

    logic [BHT_IDX_W-1:0]  w_lk_bht_idx;
    logic [BHT_IDX_W-1:0]  w_up_bht_idx;
    logic [BTB_IDX_W-1:0]  w_lk_btb_idx;
    logic [BTB_IDX_W-1:0]  w_up_btb_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_lk_taken;
    logic                  w_btb_hit;
    logic                  w_nxt_npp;
    logic [ADDR_WIDTH-1:0] w_nxt_npc;
    logic                  w_nxt_taken;
    logic                  w_unused_bits;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

`ifdef BRANCH_PREDICT_GSHARE_EN
    assign w_lk_bht_idx = bp.lookupPc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(r_ghr);
    assign w_up_bht_idx = bp.updatePc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(bp.updateGhr);
`else
    assign w_lk_bht_idx = bp.lookupPc[BHT_IDX_W+1:2];
    assign w_up_bht_idx = bp.updatePc[BHT_IDX_W+1:2];
`endif

    assign w_lk_btb_idx  = bp.lookupPc[BTB_IDX_W+1:2];
    assign w_up_btb_idx  = bp.updatePc[BTB_IDX_W+1:2];
    assign w_lk_tag      = bp.lookupPc[ADDR_WIDTH-1:BTB_IDX_W+2];
    assign w_up_tag      = bp.updatePc[ADDR_WIDTH-1:BTB_IDX_W+2];
    assign w_lk_taken    = r_bht[w_lk_bht_idx][1];
    assign w_btb_hit     = r_btb_vld[w_lk_btb_idx] && (r_btb_tag[w_lk_btb_idx] == w_lk_tag);
    assign w_unused_bits = &{1'b0, bp.lookupPc[1:0], bp.updatePc[1:0], bp.updateGhr[GHR_WIDTH-1]};

    // Next prediction bundle from the pre-update table contents
    always_comb begin
        w_nxt_npp   = 1'b0;
        w_nxt_npc   = '0;
        w_nxt_taken = 1'b0;
        if (!bp.lookupValid || !bp.lookupIsBranch) begin
            w_nxt_npp   = 1'b0;
        end else if (!w_lk_taken) begin
            w_nxt_npp   = 1'b1;
            w_nxt_npc   = bp.lookupNpc;
        end else if (w_btb_hit) begin
            w_nxt_npp   = 1'b1;
            w_nxt_npc   = r_btb_tgt[w_lk_btb_idx];
            w_nxt_taken = 1'b1;
        end else begin
            w_nxt_taken = 1'b1;
        end
    end

    // Prediction output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pred_valid <= 1'b0;
            r_pred_npp   <= 1'b0;
            r_pred_npc   <= '0;
            r_pred_taken <= 1'b0;
            r_pred_ghr   <= '0;
        end else begin
            r_pred_valid <= bp.lookupValid;
            r_pred_npp   <= w_nxt_npp;
            r_pred_npc   <= w_nxt_npc;
            r_pred_taken <= w_nxt_taken;
            r_pred_ghr   <= bp.lookupValid ? r_ghr : '0;
        end
    end

    // GHR: mispredict recovery wins over a same-cycle speculative shift
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ghr <= '0;
        end else if (bp.updateValid && bp.updateMispredict) begin
            r_ghr <= {bp.updateGhr[GHR_WIDTH-2:0], bp.updateTaken};
        end else if (bp.lookupValid && bp.lookupIsBranch) begin
            r_ghr <= {r_ghr[GHR_WIDTH-2:0], w_lk_taken};
        end else begin
            r_ghr <= r_ghr;
        end
    end

    // Direction counter training
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (bp.updateValid) begin
            r_bht[w_up_bht_idx] <= sat_step(r_bht[w_up_bht_idx], bp.updateTaken);
        end
    end

    // BTB fill on taken resolutions only
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_vld[i] <= 1'b0;
                r_btb_tag[i] <= '0;
                r_btb_tgt[i] <= '0;
            end
        end else if (bp.updateValid && bp.updateTaken) begin
            r_btb_vld[w_up_btb_idx] <= 1'b1;
            r_btb_tag[w_up_btb_idx] <= w_up_tag;
            r_btb_tgt[w_up_btb_idx] <= bp.updateTarget;
        end
    end

    assign bp.predValid             = r_pred_valid;
    assign bp.predIsNextPcPredicted = r_pred_npp;
    assign bp.predNextPc            = r_pred_npc;
    assign bp.predTaken             = r_pred_taken;
    assign bp.predGhr               = r_pred_ghr;
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed scoreboard bench for branch_predictor_unit (default bimodal build).
module tb_branch_predictor_unit;
    logic clk  = 1'b0;
    logic rstN = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_unit_if #(.ADDR_WIDTH(32), .GHR_WIDTH(8)) bp_if ();

    branch_predictor_unit #(
        .ADDR_WIDTH(32), .BHT_ENTRIES(256), .BTB_ENTRIES(64), .GHR_WIDTH(8)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bp   (bp_if.slave)
    );

    typedef struct packed {
        logic        npp;
        logic [31:0] npc;
        logic        taken;
        logic [7:0]  ghr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of lookup and/or update at the falling edge
    task automatic cyc(input bit lv, input logic [31:0] pc, input bit isb,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input logic [7:0] ughr, input bit umis);
        @(negedge clk);
        bp_if.lookupValid      = lv;
        bp_if.lookupPc         = pc;
        bp_if.lookupNpc        = pc + 32'd4;
        bp_if.lookupIsBranch   = isb;
        bp_if.updateValid      = uv;
        bp_if.updatePc         = upc;
        bp_if.updateTaken      = ut;
        bp_if.updateTarget     = utgt;
        bp_if.updateGhr        = ughr;
        bp_if.updateMispredict = umis;
    endtask

    task automatic lk(input logic [31:0] pc, input bit isb);
        cyc(1'b1, pc, isb, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0);
    endtask

    task automatic up(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, pc, t, tgt, 8'd0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0);
    endtask

    task automatic expect_pred(input bit npp, input logic [31:0] npc, input bit t, input logic [7:0] ghr);
        exp_q.push_back('{npp: npp, npc: npc, taken: t, ghr: ghr});
    endtask

    // Monitor: pop an expectation on every valid prediction, else require zeroed outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bp_if.predValid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pred: predValid=1 with no lookup pending");
                end else begin
                    e = exp_q.pop_front();
                    check("pred_npp",   {31'd0, bp_if.predIsNextPcPredicted}, {31'd0, e.npp});
                    check("pred_npc",   bp_if.predNextPc, e.npc);
                    check("pred_taken", {31'd0, bp_if.predTaken}, {31'd0, e.taken});
                    check("pred_ghr",   {24'd0, bp_if.predGhr}, {24'd0, e.ghr});
                end
            end else begin
                check("idle_zero", {bp_if.predIsNextPcPredicted, bp_if.predTaken, bp_if.predNextPc[29:0]}
                                   | {24'd0, bp_if.predGhr}, 32'd0);
            end
        end
    end

    initial begin
        bp_if.lookupValid = 1'b0;     bp_if.lookupPc = 32'd0;   bp_if.lookupNpc = 32'd0;
        bp_if.lookupIsBranch = 1'b0;  bp_if.updateValid = 1'b0; bp_if.updatePc = 32'd0;
        bp_if.updateTaken = 1'b0;     bp_if.updateTarget = 32'd0;
        bp_if.updateGhr = 8'd0;       bp_if.updateMispredict = 1'b0;
        #2 rstN = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, bp_if.predValid}, 32'd0);
        rstN = 1'b1;

        // Cold lookup: weakly not-taken, next PC = npc
        lk(32'h100, 1'b1);                     expect_pred(1'b1, 32'h104, 1'b0, 8'h00);
        up(32'h100, 1'b1, 32'h200);
        up(32'h100, 1'b1, 32'h200);
        lk(32'h100, 1'b1);                     expect_pred(1'b1, 32'h200, 1'b1, 8'h00);
        // Counter 11 -> 10: still taken
        up(32'h100, 1'b0, 32'h0);
        lk(32'h100, 1'b1);                     expect_pred(1'b1, 32'h200, 1'b1, 8'h01);
        // Same-cycle update 10 -> 01 is not yet visible to this lookup
        cyc(1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
        expect_pred(1'b1, 32'h200, 1'b1, 8'h03);
        lk(32'h100, 1'b1);                     expect_pred(1'b1, 32'h104, 1'b0, 8'h07);

        // 0x1300 aliases 0x300 in BHT and BTB index but not tag
        up(32'h1300, 1'b1, 32'h500);
        up(32'h1300, 1'b1, 32'h500);
        lk(32'h300, 1'b1);                     expect_pred(1'b0, 32'h0, 1'b1, 8'h0E);
        lk(32'h1300, 1'b1);                    expect_pred(1'b1, 32'h500, 1'b1, 8'h1D);
        lk(32'h1300, 1'b0);                    expect_pred(1'b0, 32'h0, 1'b0, 8'h3B);

        // Low saturation: 01 -> 00 -> 00 -> 00, then +1 -> 01 (not taken)
        up(32'h400, 1'b0, 32'h0);
        up(32'h400, 1'b0, 32'h0);
        up(32'h400, 1'b0, 32'h0);
        up(32'h400, 1'b1, 32'h800);
        lk(32'h400, 1'b1);                     expect_pred(1'b1, 32'h404, 1'b0, 8'h3B);

        // Three predicted-taken lookups (BTB slot now tagged for 0x400 -> miss)
        lk(32'h1300, 1'b1);                    expect_pred(1'b0, 32'h0, 1'b1, 8'h76);
        lk(32'h1300, 1'b1);                    expect_pred(1'b0, 32'h0, 1'b1, 8'hED);
        lk(32'h1300, 1'b1);                    expect_pred(1'b0, 32'h0, 1'b1, 8'hDB);
        // Mispredict recovery beats the same-cycle speculative shift
        cyc(1'b1, 32'h1300, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0, 8'b0000_0101, 1'b1);
        expect_pred(1'b0, 32'h0, 1'b1, 8'hB7);
        lk(32'h1300, 1'b0);                    expect_pred(1'b0, 32'h0, 1'b0, 8'h0A);
        idle();

        // Reset while a lookup is presented: no prediction, tables back to reset state
        cyc(1'b1, 32'h1300, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 8'd0, 1'b0);
        rstN = 1'b0;
        @(negedge clk);
        check("reset_drop_valid", {31'd0, bp_if.predValid}, 32'd0);
        bp_if.lookupValid = 1'b0;
        rstN = 1'b1;
        lk(32'h1300, 1'b1);                    expect_pred(1'b1, 32'h1304, 1'b0, 8'h00);
        idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
